// File: rtl/thmn_gate_array.sv
// thmn_gate_array: clocked functional model of CH parallel NCL THmn threshold
// gates with hysteresis, plus a DATA/NULL completion tracker and an input
// monotonicity checker.
//
// Ports:
//   clk       - sole clock, all state updates on the rising edge
//   rst_n     - synchronous active-low reset
//   x         - gate inputs, channel k uses x[k*N +: N]
//   err_clr   - clears all sticky error bits (a same-edge violation wins)
//   y         - registered gate outputs, one per channel
//   all_data  - every y bit is 1
//   all_null  - every y bit is 0
//   phase     - tracker state, 0 = waiting for DATA, 1 = waiting for NULL
//   wave_cnt  - completed DATA->NULL waves, wraps silently
//   err       - sticky per-channel monotonicity violation
module thmn_gate_array #(
  parameter int unsigned   N         = 4,
  parameter int unsigned   M         = 4,
  parameter int unsigned   CH        = 2,
  parameter bit            HYST      = 1'b1,
  parameter logic [CH-1:0] RESET_VAL = '0,
  parameter bit            CHECK_EN  = 1'b1,
  parameter int unsigned   CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH*N-1:0]   x,
  input  logic              err_clr,
  output logic [CH-1:0]     y,
  output logic              all_data,
  output logic              all_null,
  output logic              phase,
  output logic [CNT_W-1:0]  wave_cnt,
  output logic [CH-1:0]     err
);

  // Elaboration-time parameter sanity checks.
  if (M < 1 || M > N) begin : g_bad_m
    $error("thmn_gate_array: threshold M must satisfy 1 <= M <= N");
  end
  if (N < 1 || N > 16) begin : g_bad_n
    $error("thmn_gate_array: N must be in 1..16");
  end
  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("thmn_gate_array: CH must be in 1..32");
  end

  // Monotonicity checking only makes sense for hysteresis gates.
  localparam bit ChkOn = CHECK_EN && HYST;

  typedef enum logic [0:0] {
    StWaitData = 1'b0,
    StWaitNull = 1'b1
  } phase_e;

  logic [CH-1:0]    y_q, y_d;
  logic [CH-1:0]    err_q, err_d;
  logic [CH-1:0]    viol;
  logic [CH*N-1:0]  x_q;
  logic             prev_vld_q;
  phase_e           state_q, state_d;
  logic [CNT_W-1:0] wave_q, wave_d;

  function automatic int unsigned popcnt(input logic [N-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < int'(N); i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

  // Gate next state: set at >= M, clear at 0, otherwise hold (or plain threshold).
  always_comb begin
    y_d = y_q;
    for (int k = 0; k < int'(CH); k++) begin
      if (!HYST) begin
        y_d[k] = (popcnt(x[k*N +: N]) >= M);
      end else if (popcnt(x[k*N +: N]) >= M) begin
        y_d[k] = 1'b1;
      end else if (popcnt(x[k*N +: N]) == 0) begin
        y_d[k] = 1'b0;
      end
    end
  end

  // Checker compares against the pre-update y, so a fall on the edge y sets is legal.
  always_comb begin
    viol = '0;
    if (ChkOn && prev_vld_q) begin
      for (int k = 0; k < int'(CH); k++) begin
        if (y_q[k]) begin
          // DATA re-injected before NULL completed.
          viol[k] = |(x[k*N +: N] & ~x_q[k*N +: N]);
        end else begin
          // DATA wave retracted before completion.
          viol[k] = (|(x_q[k*N +: N] & ~x[k*N +: N])) && (|x_q[k*N +: N]);
        end
      end
    end
    err_d = (err_q & ~{CH{err_clr}}) | viol;
  end

  // Completion tracker, driven by registered y so it lags the gates by a cycle.
  always_comb begin
    state_d = state_q;
    wave_d  = wave_q;
    case (state_q)
      StWaitData: begin
        if (all_data) begin
          state_d = StWaitNull;
        end
      end
      StWaitNull: begin
        if (all_null) begin
          state_d = StWaitData;
          wave_d  = wave_q + CNT_W'(1);
        end
      end
      default: state_d = StWaitData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q        <= RESET_VAL;
      err_q      <= '0;
      x_q        <= '0;
      prev_vld_q <= 1'b0;
      state_q    <= StWaitData;
      wave_q     <= '0;
    end else begin
      y_q        <= y_d;
      err_q      <= err_d;
      x_q        <= x;
      prev_vld_q <= 1'b1;
      state_q    <= state_d;
      wave_q     <= wave_d;
    end
  end

  assign y        = y_q;
  assign all_data = &y_q;
  assign all_null = ~|y_q;
  assign phase    = (state_q == StWaitNull);
  assign wave_cnt = wave_q;
  assign err      = err_q;

endmodule

// File: tb/tb_thmn_gate_array.sv
// Directed bench for thmn_gate_array covering three configurations:
//   u_a - defaults (N=4, M=4, CH=2, HYST=1, CNT_W=8)
//   u_b - CNT_W=2, RESET_VAL=2'b10
//   u_c - plain threshold, N=3, M=2, CH=2
module tb_thmn_gate_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // u_a
  logic       rst_a, clr_a;
  logic [7:0] x_a;
  logic [1:0] y_a, err_a;
  logic       ad_a, an_a, ph_a;
  logic [7:0] wc_a;

  // u_b
  logic       rst_b, clr_b;
  logic [7:0] x_b;
  logic [1:0] y_b, err_b;
  logic       ad_b, an_b, ph_b;
  logic [1:0] wc_b;

  // u_c
  logic       rst_c, clr_c;
  logic [5:0] x_c;
  logic [1:0] y_c, err_c;
  logic       ad_c, an_c, ph_c;
  logic [7:0] wc_c;

  thmn_gate_array u_a (
    .clk      (clk),
    .rst_n    (rst_a),
    .x        (x_a),
    .err_clr  (clr_a),
    .y        (y_a),
    .all_data (ad_a),
    .all_null (an_a),
    .phase    (ph_a),
    .wave_cnt (wc_a),
    .err      (err_a)
  );

  thmn_gate_array #(
    .CNT_W     (2),
    .RESET_VAL (2'b10)
  ) u_b (
    .clk      (clk),
    .rst_n    (rst_b),
    .x        (x_b),
    .err_clr  (clr_b),
    .y        (y_b),
    .all_data (ad_b),
    .all_null (an_b),
    .phase    (ph_b),
    .wave_cnt (wc_b),
    .err      (err_b)
  );

  thmn_gate_array #(
    .N    (3),
    .M    (2),
    .HYST (1'b0)
  ) u_c (
    .clk      (clk),
    .rst_n    (rst_c),
    .x        (x_c),
    .err_clr  (clr_c),
    .y        (y_c),
    .all_data (ad_c),
    .all_null (an_c),
    .phase    (ph_c),
    .wave_cnt (wc_c),
    .err      (err_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] ramp_up [4];
  logic [3:0] ramp_dn [3];

  initial begin
    ramp_up = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    ramp_dn = '{4'b0111, 4'b0011, 4'b0001};

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    x_a = '0; x_b = '0; x_c = '0;
    step();
    step();
    rst_a = 1'b1;
    rst_c = 1'b1;

    // Reset state of the default configuration.
    check_eq("a_rst_y",     32'(y_a),  32'h0);
    check_eq("a_rst_null",  32'(an_a), 32'h1);
    check_eq("a_rst_data",  32'(ad_a), 32'h0);
    check_eq("a_rst_phase", 32'(ph_a), 32'h0);
    check_eq("a_rst_wave",  32'(wc_a), 32'h0);
    check_eq("a_rst_err",   32'(err_a), 32'h0);

    // Ch0 C-element ramp up, then down.
    for (int i = 0; i < 4; i++) begin
      x_a = {4'h0, ramp_up[i]};
      step();
      check_eq("a_ramp_up_y", 32'(y_a), (i == 3) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      x_a = {4'h0, ramp_dn[i]};
      step();
      check_eq("a_ramp_dn_y", 32'(y_a), 32'h1);
    end
    x_a = 8'h00;
    step();
    check_eq("a_null_y",    32'(y_a),   32'h0);
    check_eq("a_ramp_err",  32'(err_a), 32'h0);
    check_eq("a_ramp_phase", 32'(ph_a), 32'h0);

    // Three full waves on both channels.
    for (int w = 0; w < 3; w++) begin
      x_a = 8'hFF;
      step();
      check_eq("a_wave_y",    32'(y_a),  32'h3);
      check_eq("a_wave_data", 32'(ad_a), 32'h1);
      x_a = 8'h00;
      step();
      check_eq("a_wave_ph1",  32'(ph_a), 32'h1);
      step();
      check_eq("a_wave_ph0",  32'(ph_a), 32'h0);
      check_eq("a_wave_cnt",  32'(wc_a), 32'(w + 1));
    end
    check_eq("a_wave_err", 32'(err_a), 32'h0);

    // Ch1 retraction before completion.
    x_a = 8'h30;
    step();
    check_eq("a_ch1_part_err", 32'(err_a), 32'h0);
    x_a = 8'h10;
    step();
    check_eq("a_ch1_viol_err", 32'(err_a), 32'h2);
    x_a = 8'h30;
    step();
    check_eq("a_ch1_sticky",   32'(err_a), 32'h2);
    x_a = 8'h10;
    clr_a = 1'b1;
    step();
    check_eq("a_clr_vs_viol",  32'(err_a), 32'h2);
    step();
    check_eq("a_clr_alone",    32'(err_a), 32'h0);
    clr_a = 1'b0;
    check_eq("a_ch1_y",        32'(y_a),   32'h0);

    // u_b: first post-reset cycle presents full DATA on ch1 while y[1] = 1.
    check_eq("b_rst_y", 32'(y_b), 32'h2);
    x_b = 8'hFF;
    rst_b = 1'b1;
    step();
    check_eq("b_first_y",   32'(y_b),   32'h3);
    check_eq("b_first_err", 32'(err_b), 32'h0);
    x_b = 8'h00;
    step();
    step();
    check_eq("b_wave_cnt", 32'(wc_b), 32'h1);
    for (int w = 1; w < 5; w++) begin
      x_b = 8'hFF;
      step();
      x_b = 8'h00;
      step();
      step();
      check_eq("b_wave_wrap", 32'(wc_b), 32'((w + 1) % 4));
    end
    check_eq("b_wave_err", 32'(err_b), 32'h0);

    // Reset mid-wave.
    x_b = 8'hFF;
    step();
    step();
    check_eq("b_mid_phase", 32'(ph_b), 32'h1);
    check_eq("b_mid_y",     32'(y_b),  32'h3);
    rst_b = 1'b0;
    step();
    check_eq("b_rst2_y",     32'(y_b),   32'h2);
    check_eq("b_rst2_wave",  32'(wc_b),  32'h0);
    check_eq("b_rst2_phase", 32'(ph_b),  32'h0);
    check_eq("b_rst2_err",   32'(err_b), 32'h0);
    rst_b = 1'b1;
    step();
    check_eq("b_post_err", 32'(err_b), 32'h0);
    check_eq("b_post_y",   32'(y_b),   32'h3);
    step();
    check_eq("b_post_err2", 32'(err_b), 32'h0);

    // u_c: plain threshold 2-of-3.
    check_eq("c_rst_y", 32'(y_c), 32'h0);
    x_c = 6'b000_011;
    step();
    check_eq("c_thr_set", 32'(y_c), 32'h1);
    x_c = 6'b000_001;
    step();
    check_eq("c_thr_clr", 32'(y_c), 32'h0);
    x_c = 6'b110_011;
    step();
    check_eq("c_both_y", 32'(y_c), 32'h3);
    x_c = 6'b111_001;
    step();
    check_eq("c_mix_y", 32'(y_c),   32'h2);
    check_eq("c_err",   32'(err_c), 32'h0);
    x_c = 6'b000_000;
    step();
    check_eq("c_zero_y",   32'(y_c),   32'h0);
    check_eq("c_zero_err", 32'(err_c), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/thmn_gate_array.md
Name: thmn_gate_array

Overview:
- Clocked functional-simulation model of CH parallel NCL THmn threshold gates with hysteresis.
- Parametrised in input count N, threshold M, channel count and mode; generalises the fixed 4-of-4 gate.
- Per-channel reset value, a DATA/NULL completion tracker with a wave counter, and an input-monotonicity checker.
- Used in gate-level-abstracted NCL pipelines and as a bench reference model for transistor-level cells.

Parameters:
- N, 4, inputs per gate (1..16).
- M, 4, threshold; elaboration error unless 1 <= M <= N.
- CH, 2, number of independent gate channels (1..32).
- HYST, 1, 1 = NCL hysteresis (set at >=M, clear at 0, else hold); 0 = plain threshold (y = count >= M).
- RESET_VAL, {CH{1'b0}}, per-channel output value on reset (NULL = 0, DATA = 1).
- CHECK_EN, 1, enables the monotonicity checker; forced inactive when HYST = 0.
- CNT_W, 8, width of the wave counter.

Ports:
- clk, input, 1, sole clock; all state updates on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- x, input, CH*N, gate inputs; channel k uses x[k*N +: N].
- err_clr, input, 1, clears all sticky error bits.
- y, output, CH, registered gate outputs.
- all_data, output, 1, high when every y bit is 1 (combinational from y register).
- all_null, output, 1, high when every y bit is 0 (combinational from y register).
- phase, output, 1, tracker state: 0 = WAIT_DATA, 1 = WAIT_NULL.
- wave_cnt, output, CNT_W, completed DATA→NULL waves, modulo 2^CNT_W.
- err, output, CH, sticky per-channel monotonicity violation.

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - y <= RESET_VAL; phase <= WAIT_DATA; wave_cnt <= 0; err <= 0; x_q <= 0; prev_vld <= 0.
  - Reset asserted mid-operation discards all state identically.
- Gate update, per channel k, one-cycle latency:
  - cnt_k = popcount of channel k's slice of x.
  - HYST = 1: cnt_k >= M → y[k] <= 1; cnt_k == 0 → y[k] <= 0; otherwise y[k] holds.
  - HYST = 0: y[k] <= (cnt_k >= M).
  - When M == N and HYST = 1, the gate behaves as an N-input C-element.
- Tracker state machine, evaluated on registered y (so it lags y by one cycle):
  - WAIT_DATA, all_data = 1 → WAIT_NULL.
  - WAIT_NULL, all_null = 1 → WAIT_DATA, and wave_cnt increments (wraps 2^CNT_W - 1 → 0 silently).
  - Otherwise the state holds.
  - CH = 1 with y toggling every cycle gives one increment per 0→1→0 pair.
- Checker (active when CHECK_EN = 1, HYST = 1 and prev_vld = 1):
  - x_q holds the previous cycle's x; prev_vld sets 1 on the first clock after reset.
  - Violation on channel k if y[k] == 0 and any bit of the slice falls 1→0 while x_q's slice is non-zero (DATA wave retracted before completion).
  - Violation on channel k if y[k] == 1 and any bit rises 0→1 (DATA re-injected before NULL completed).
  - A violation sets err[k] on the next edge; err is sticky.
  - err_clr clears all bits on the next edge; a simultaneous violation on channel k wins, so err[k] = 1.
- Checks use the pre-update y (same-edge comparison), so an input falling on the cycle y sets is legal.
- No X-propagation handling is required; inputs are assumed driven after reset.

Test Plan:
- Defaults, rst_n low 2 cycles, then x = 0 → y = 00, all_null = 1, phase = 0, wave_cnt = 0, err = 00.
- Ch0 inputs raised one bit per cycle 0001, 0011, 0111, 1111 → y[0] stays 0 until the cycle after 1111, then 1; lowered 0111, 0011, 0001 → y[0] holds 1; 0000 → y[0] = 0 next cycle.
- Both channels driven to 1111 then 0000, repeated 3 times → wave_cnt = 3, phase toggles 0→1→0 per wave; with CNT_W = 2, 5 waves → wave_cnt = 1.
- Ch1: x = 0011, then 0001 while y[1] = 0 → err[1] = 1 next cycle, err[0] = 0; err_clr in the same cycle as a new ch1 violation → err[1] stays 1; err_clr alone → 0.
- HYST = 0, M = 2, N = 3: ch0 x = 011 → y[0] = 1; x = 001 → y[0] = 0 next cycle; err stays 0 throughout.
- RESET_VAL = 2'b10, rst_n pulsed low mid-wave with y = 11 → y = 10, wave_cnt = 0, phase = 0; first post-reset cycle x = 1111 on ch1 does not flag err[1].
